// File: rtl/cfg_bank_arbiter.sv
// ============================================================================
// cfg_bank_arbiter: round-robin two-port writer for the PWM configuration bank,
// with optional staging committed at PWM period boundaries (CFG_BANK_SHADOW_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfg_bank_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              period_end,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              dirty,
  output logic              commit,
  output logic              addr_err
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int c_NREGS = 5;

  state_t              r_state;
  logic                r_prio_b;
  logic                r_win_b;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_a_ack;
  logic                r_b_ack;
  logic                r_addr_err;
  logic [DATA_W-1:0]   r_active [c_NREGS];
`ifdef CFG_BANK_SHADOW_EN
  logic [DATA_W-1:0]   r_stage  [c_NREGS];
  logic                r_dirty;
  logic                r_commit;
`endif

  // A requester is still holding its just-acked transfer during the ack
  // cycle, so it is masked for that one cycle to avoid a duplicate grant.
  logic                w_a_req;
  logic                w_b_req;
  logic                w_pick_b;
  logic                w_addr_ok;
  logic [2:0]          w_idx;

  assign w_a_req   = a_valid & ~r_a_ack;
  assign w_b_req   = b_valid & ~r_b_ack;
  assign w_pick_b  = w_b_req & (~w_a_req | r_prio_b);
  assign w_addr_ok = (r_addr < ADDR_W'(c_NREGS));
  assign w_idx     = r_addr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prio_b   <= 1'b0;
      r_win_b    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_addr_err <= 1'b0;
      for (int i = 0; i < c_NREGS; i++) begin
        r_active[i] <= '0;
      end
`ifdef CFG_BANK_SHADOW_EN
      for (int i = 0; i < c_NREGS; i++) begin
        r_stage[i] <= '0;
      end
      r_dirty  <= 1'b0;
      r_commit <= 1'b0;
`endif
    end else begin
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_addr_err <= 1'b0;
`ifdef CFG_BANK_SHADOW_EN
      // Commit reads pre-write staging; a coinciding grant write overrides dirty.
      r_commit <= 1'b0;
      if (period_end && r_dirty) begin
        r_active <= r_stage;
        r_dirty  <= 1'b0;
        r_commit <= 1'b1;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (w_a_req || w_b_req) begin
            r_win_b <= w_pick_b;
            r_addr  <= w_pick_b ? b_addr : a_addr;
            r_data  <= w_pick_b ? b_data : a_data;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_a_ack  <= ~r_win_b;
          r_b_ack  <= r_win_b;
          r_prio_b <= ~r_win_b;
          r_state  <= S_IDLE;
          if (w_addr_ok) begin
`ifdef CFG_BANK_SHADOW_EN
            r_stage[w_idx] <= r_data;
            r_dirty        <= 1'b1;
`else
            r_active[w_idx] <= r_data;
`endif
          end else begin
            r_addr_err <= 1'b1;
          end
        end
      endcase
    end
  end

  assign a_ack           = r_a_ack;
  assign b_ack           = r_b_ack;
  assign addr_err        = r_addr_err;
  assign en_reg_out_7_0  = r_active[0];
  assign en_reg_out_15_8 = r_active[1];
  assign en_reg_pwm_7_0  = r_active[2];
  assign en_reg_pwm_15_8 = r_active[3];
  assign pwm_duty_cycle  = r_active[4];

`ifdef CFG_BANK_SHADOW_EN
  assign dirty  = r_dirty;
  assign commit = r_commit;
`else
  wire w_unused_period_end;
  assign w_unused_period_end = period_end;
  assign dirty  = 1'b0;
  assign commit = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cfg_bank_arbiter.sv
// ============================================================================
// tb_cfg_bank_arbiter: directed + randomized bench with a transaction-level
// reference model of the configuration bank arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cfg_bank_arbiter;

`ifdef CFG_BANK_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, period_end = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ack, b_ack, dirty, commit, addr_err;
  logic [7:0] r0, r1, r2, r3, r4;

  cfg_bank_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .period_end(period_end),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .dirty(dirty), .commit(commit), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one write transaction "in flight" at a time, acked and
  // applied one cycle after it is chosen; a port is not eligible in its ack cycle.
  logic       m_busy, m_who_b, m_turn_b, m_dirty;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_stage [0:4];
  logic [7:0] m_act   [0:4];
  logic       e_a_ack, e_b_ack, e_err, e_commit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_who_b = 0; m_turn_b = 0; m_dirty = 0; m_addr = '0; m_data = '0;
      for (int i = 0; i < 5; i++) begin m_stage[i] = '0; m_act[i] = '0; end
      e_a_ack = 0; e_b_ack = 0; e_err = 0; e_commit = 0;
    end else begin
      logic ar, br;
      int   idx;
      ar = a_valid && !e_a_ack;
      br = b_valid && !e_b_ack;
      e_a_ack = 0; e_b_ack = 0; e_err = 0; e_commit = 0;
      if (SH && period_end && m_dirty) begin
        for (int i = 0; i < 5; i++) m_act[i] = m_stage[i];
        m_dirty  = 0;
        e_commit = 1;
      end
      if (m_busy) begin
        if (m_who_b) e_b_ack = 1; else e_a_ack = 1;
        idx = int'(m_addr);
        if (idx < 5) begin
          if (SH) begin m_stage[idx] = m_data; m_dirty = 1; end
          else m_act[idx] = m_data;
        end else begin
          e_err = 1;
        end
        m_turn_b = !m_who_b;
        m_busy   = 0;
      end else if (ar || br) begin
        m_who_b = br && (!ar || m_turn_b);
        m_addr  = m_who_b ? b_addr : a_addr;
        m_data  = m_who_b ? b_data : a_data;
        m_busy  = 1;
      end
    end
  end

  task automatic compare_all();
    check("a_ack",    32'(a_ack),    32'(e_a_ack));
    check("b_ack",    32'(b_ack),    32'(e_b_ack));
    check("addr_err", 32'(addr_err), 32'(e_err));
    check("commit",   32'(commit),   32'(e_commit));
    check("dirty",    32'(dirty),    32'(m_dirty));
    check("reg0",     32'(r0), 32'(m_act[0]));
    check("reg1",     32'(r1), 32'(m_act[1]));
    check("reg2",     32'(r2), 32'(m_act[2]));
    check("reg3",     32'(r3), 32'(m_act[3]));
    check("reg4",     32'(r4), 32'(m_act[4]));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  logic a_seen = 0, b_seen = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 0; b_valid = 0; period_end = 0; a_seen = 0; b_seen = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ack_a();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (a_ack) break;
    end
    if (!a_ack) check("a_ack_timeout", 32'(a_ack), 32'd1);
  endtask

  task automatic wait_ack_b();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (b_ack) break;
    end
    if (!b_ack) check("b_ack_timeout", 32'(b_ack), 32'd1);
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  function automatic logic [6:0] gen_addr();
    if ($urandom_range(0, 7) == 0) return 7'($urandom_range(5, 127));
    return 7'($urandom_range(0, 4));
  endfunction

  task automatic rand_drive();
    if (a_seen) begin
      a_seen = 0;
      if ($urandom_range(0, 3) != 0) begin
        a_valid = 1; a_addr = gen_addr(); a_data = 8'($urandom);
      end else a_valid = 0;
    end else if (a_ack) a_seen = 1;
    else if (!a_valid && $urandom_range(0, 2) == 0) begin
      a_valid = 1; a_addr = gen_addr(); a_data = 8'($urandom);
    end
    if (b_seen) begin
      b_seen = 0;
      if ($urandom_range(0, 3) != 0) begin
        b_valid = 1; b_addr = gen_addr(); b_data = 8'($urandom);
      end else b_valid = 0;
    end else if (b_ack) b_seen = 1;
    else if (!b_valid && $urandom_range(0, 2) == 0) begin
      b_valid = 1; b_addr = gen_addr(); b_data = 8'($urandom);
    end
    period_end = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    int ca, cb, na, nb, last, alt_ok;
    #2;
    do_reset();

    // Single A write to duty cycle, then commit.
    a_valid = 1; a_addr = 7'h04; a_data = 8'h80;
    wait_ack_a();
    check("t1_dirty_after_ack", 32'(dirty), 32'(SH));
    check("t1_duty_before_pe", 32'(r4), SH ? 32'h00 : 32'h80);
    tick(); a_valid = 0;
    pulse_pe();
    check("t1_duty_after_pe", 32'(r4), 32'h80);
    check("t1_commit", 32'(commit), 32'(SH));
    tick();

    // Simultaneous A/B from reset.
    do_reset();
    a_valid = 1; a_addr = 7'h00; a_data = 8'h11;
    b_valid = 1; b_addr = 7'h01; b_data = 8'h22;
    ca = -1; cb = -1;
    for (int k = 0; k < 12 && (ca < 0 || cb < 0); k++) begin
      tick();
      if (a_ack) begin ca = cyc; end
      else if (ca >= 0) a_valid = 0;
      if (b_ack) begin cb = cyc; end
      else if (cb >= 0) b_valid = 0;
    end
    check("t2_b_after_a", 32'(cb - ca), 32'd2);
    tick(); a_valid = 0; b_valid = 0;
    pulse_pe();
    check("t2_reg0", 32'(r0), 32'h11);
    check("t2_reg1", 32'(r1), 32'h22);

    // Continuous contention: 8 grants alternate.
    do_reset();
    a_valid = 1; a_addr = 7'h02; a_data = 8'h01;
    b_valid = 1; b_addr = 7'h03; b_data = 8'h02;
    na = 0; nb = 0; last = -1; alt_ok = 1;
    for (int k = 0; k < 40 && (na + nb) < 8; k++) begin
      tick();
      if (a_seen) begin a_seen = 0; a_data = 8'($urandom); end
      if (b_seen) begin b_seen = 0; b_data = 8'($urandom); end
      if (a_ack) begin na++; if (last == 0) alt_ok = 0; last = 0; a_seen = 1; end
      if (b_ack) begin nb++; if (last == 1) alt_ok = 0; last = 1; b_seen = 1; end
    end
    a_valid = 0; b_valid = 0; a_seen = 0; b_seen = 0;
    check("t3_acks_a", 32'(na), 32'd4);
    check("t3_acks_b", 32'(nb), 32'd4);
    check("t3_alternate", 32'(alt_ok), 32'd1);
    for (int k = 0; k < 4; k++) tick();

    // Bad address on B.
    do_reset();
    b_valid = 1; b_addr = 7'h05; b_data = 8'hFF;
    wait_ack_b();
    check("t4_addr_err", 32'(addr_err), 32'd1);
    check("t4_dirty", 32'(dirty), 32'd0);
    tick(); b_valid = 0;
    pulse_pe();
    check("t4_no_commit", 32'(commit), 32'd0);
    check("t4_duty", 32'(r4), 32'd0);

    // Grant write coinciding with commit.
    do_reset();
    a_valid = 1; a_addr = 7'h03; a_data = 8'hAA;
    wait_ack_a();
    tick(); a_valid = 0;
    tick();
    a_valid = 1; a_addr = 7'h02; a_data = 8'h0F;
    tick();
    period_end = 1;
    tick();
    period_end = 0;
    check("t5_coinc_ack", 32'(a_ack), 32'd1);
    check("t5_pwm15_8", 32'(r3), 32'hAA);
    check("t5_pwm7_0", 32'(r2), SH ? 32'h00 : 32'h0F);
    check("t5_dirty", 32'(dirty), 32'(SH));
    tick(); a_valid = 0;
    pulse_pe();
    check("t5_pwm7_0_next", 32'(r2), 32'h0F);

    // Reset during GRANT, then a normal grant.
    a_valid = 1; a_addr = 7'h04; a_data = 8'h40;
    tick();
    rst = 1;
    a_seen = 0;
    tick();
    check("t6_no_ack", 32'(a_ack), 32'd0);
    check("t6_duty_zero", 32'(r4), 32'd0);
    rst = 0;
    wait_ack_a();
    check("t6_regrant_duty", 32'(r4), SH ? 32'h00 : 32'h40);
    tick(); a_valid = 0;
    tick();

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      tick();
      rand_drive();
    end
    a_valid = 0; b_valid = 0; period_end = 0;
    for (int k = 0; k < 4; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
